// File: rtl/scale_mux_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : scale_mux_fifo_if
// Brief    : Write/read handshake bundle for scale_mux_fifo. Defining
//            SCALE_MUX_FIFO_ERR_EN adds the sticky o_ovf/o_udf flags.
// Revision : 1.0 - initial release
// ============================================================================
interface scale_mux_fifo_if #(
  parameter int size  = 7,
  parameter int DEPTH = 4
);
  logic                     i_wr_en;
  logic [size:0]            i_wr_data;
  logic                     i_rd_en;
  logic [size:0]            o_rd_data;
  logic                     o_rd_valid;
  logic                     o_full;
  logic                     o_empty;
  logic [$clog2(DEPTH):0]   o_count;
`ifdef SCALE_MUX_FIFO_ERR_EN
  logic                     o_ovf;
  logic                     o_udf;
`endif

  // Producer/consumer side
  modport master (
    output i_wr_en, i_wr_data, i_rd_en,
`ifdef SCALE_MUX_FIFO_ERR_EN
    input  o_ovf, o_udf,
`endif
    input  o_rd_data, o_rd_valid, o_full, o_empty, o_count
  );

  // FIFO side
  modport slave (
    input  i_wr_en, i_wr_data, i_rd_en,
`ifdef SCALE_MUX_FIFO_ERR_EN
    output o_ovf, o_udf,
`endif
    output o_rd_data, o_rd_valid, o_full, o_empty, o_count
  );
endinterface
`default_nettype wire

// File: rtl/scale_mux_fifo.sv
`default_nettype none
// ============================================================================
// Module   : scale_mux_fifo
// Brief    : Synchronous FIFO behind the scale mux with a registered,
//            one-cycle-latency read port. Optional macro:
//            SCALE_MUX_FIFO_ERR_EN (sticky overflow/underflow flags).
// Revision : 1.0 - initial release
// ============================================================================
module scale_mux_fifo #(
  parameter int size  = 7,
  parameter int DEPTH = 4
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst_n,
  scale_mux_fifo_if.slave  bus
);
  localparam int               c_aw       = $clog2(DEPTH);
  localparam logic [c_aw:0]    c_full_cnt = (c_aw + 1)'(DEPTH);

  logic [size:0]   r_mem [DEPTH];
  logic [c_aw-1:0] r_wptr;
  logic [c_aw-1:0] r_rptr;
  logic [c_aw:0]   r_count;
  logic [size:0]   r_rd_data;
  logic            r_rd_valid;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags come from the registered count only, so no input reaches an output
  assign w_full   = (r_count == c_full_cnt);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = bus.i_wr_en & ~w_full;
  assign w_rd_acc = bus.i_rd_en & ~w_empty;

  // Storage is intentionally left out of reset
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_wr_acc) begin
      r_mem[r_wptr] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + c_aw'(1);
      end
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rptr];
        r_rptr    <= r_rptr + c_aw'(1);
      end
      r_rd_valid <= w_rd_acc;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (c_aw + 1)'(1);
        2'b01:   r_count <= r_count - (c_aw + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SCALE_MUX_FIFO_ERR_EN
  logic r_ovf;
  logic r_udf;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (bus.i_wr_en && w_full) begin
        r_ovf <= 1'b1;
      end
      if (bus.i_rd_en && w_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign bus.o_ovf = r_ovf;
  assign bus.o_udf = r_udf;
`endif

  assign bus.o_rd_data  = r_rd_data;
  assign bus.o_rd_valid = r_rd_valid;
  assign bus.o_full     = w_full;
  assign bus.o_empty    = w_empty;
  assign bus.o_count    = r_count;
endmodule
`default_nettype wire

// File: tb/tb_scale_mux_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_scale_mux_fifo
// Brief    : Directed plus randomized checks of scale_mux_fifo against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scale_mux_fifo;
  localparam int c_size  = 7;
  localparam int c_depth = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [c_size:0] model_q [$];
  logic [c_size:0] exp_data;
  logic            exp_valid;
  logic            exp_ovf;
  logic            exp_udf;

  scale_mux_fifo_if #(.size(c_size), .DEPTH(c_depth)) bus ();

  scale_mux_fifo #(.size(c_size), .DEPTH(c_depth)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock: drive requests, advance model on the edge, compare after it
  task automatic step(input logic rst_in, input logic wr, input logic [c_size:0] d, input logic rd);
    bit was_full, was_empty;
    rst_n         = rst_in;
    bus.i_wr_en   = wr;
    bus.i_wr_data = d;
    bus.i_rd_en   = rd;
    @(posedge clk);
    was_full  = (model_q.size() == c_depth);
    was_empty = (model_q.size() == 0);
    if (!rst_in) begin
      model_q.delete();
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_udf   = 1'b0;
    end else begin
      if (wr && was_full)  exp_ovf = 1'b1;
      if (rd && was_empty) exp_udf = 1'b1;
      if (rd && !was_empty) begin
        exp_data  = model_q.pop_front();
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      if (wr && !was_full) model_q.push_back(d);
    end
    #1;
    check("count",    32'(bus.o_count),    32'(model_q.size()));
    check("full",     32'(bus.o_full),     32'(model_q.size() == c_depth));
    check("empty",    32'(bus.o_empty),    32'(model_q.size() == 0));
    check("rd_valid", 32'(bus.o_rd_valid), 32'(exp_valid));
    check("rd_data",  32'(bus.o_rd_data),  32'(exp_data));
`ifdef SCALE_MUX_FIFO_ERR_EN
    check("ovf",      32'(bus.o_ovf),      32'(exp_ovf));
    check("udf",      32'(bus.o_udf),      32'(exp_udf));
`endif
  endtask

  initial begin
    logic [7:0] fill_pat [4];
    fill_pat[0] = 8'h00; fill_pat[1] = 8'hff; fill_pat[2] = 8'h0f; fill_pat[3] = 8'hf0;
    rst_n = 1'b0;
    bus.i_wr_en = 1'b0; bus.i_wr_data = '0; bus.i_rd_en = 1'b0;
    exp_data = '0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;

    // Reset then idle
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Fill, overflow attempt, drain, underflow attempt
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, fill_pat[i], 1'b0);
    step(1'b1, 1'b1, 8'haa, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);

    // Simultaneous read/write at count 2
    step(1'b1, 1'b1, 8'h11, 1'b0);
    step(1'b1, 1'b1, 8'h22, 1'b0);
    step(1'b1, 1'b1, 8'h33, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);

    // Wrap-around with paired write/read traffic
    step(1'b1, 1'b1, 8'h01, 1'b0);
    for (int k = 2; k <= 10; k++) step(1'b1, 1'b1, 8'(k), 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);

    // Reset mid-operation with both requests active
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b1);
    step(1'b1, 1'b1, 8'h5a, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) != 0), 1'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
